bip_ctrl: RTL and testbench

Multi-cycle control unit for the 16-bit accumulator datapath. Fetches 16-bit instructions from a synchronous program ROM, decodes them, and sequences the accumulator (`WrAcc`/`Clear`), the operand mux/negator and the synchronous data RAM. It is the only driver of the accumulator control inputs and the data-memory strobes in the processor top level.

---
 rtl/bip_ctrl.sv | 137 +++++++++++++
 tb/tb_bip_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_ctrl.sv
// bip_ctrl: multi-cycle control unit for the 16-bit accumulator datapath.
// Fetches instructions from a synchronous program ROM, decodes them and
// sequences the accumulator, operand mux/negator and synchronous data RAM.
//
// Ports:
//   clk       rising-edge clock
//   Reset     synchronous, active-high reset
//   Start     begin execution at address 0 (honoured only in IDLE or HALT)
//   PcAddr    program ROM address
//   InstrIn   ROM read data, valid one cycle after PcAddr
//   DataAddr  data RAM address (IR[10:0])
//   DataRd    data RAM read strobe
//   DataWr    data RAM write strobe
//   SelSrc    operand mux select: 0 = ImmOut, 1 = RAM read data
//   Negate    two's-complement the selected operand
//   ImmOut    IR[10:0] sign-extended to 16 bits
//   WrAcc     accumulator write (acc <= acc + operand)
//   Clear     accumulator clear
//   Busy      high in every state except IDLE and HALT
//   Halted    high in HALT
module bip_ctrl #(
  parameter int unsigned PC_W = 11
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            Start,
  output logic [PC_W-1:0] PcAddr,
  input  logic [15:0]     InstrIn,
  output logic [10:0]     DataAddr,
  output logic            DataRd,
  output logic            DataWr,
  output logic            SelSrc,
  output logic            Negate,
  output logic [15:0]     ImmOut,
  output logic            WrAcc,
  output logic            Clear,
  output logic            Busy,
  output logic            Halted
);

  localparam logic [4:0] OpHlt  = 5'b00000;
  localparam logic [4:0] OpSto  = 5'b00001;
  localparam logic [4:0] OpLd   = 5'b00010;
  localparam logic [4:0] OpLdi  = 5'b00011;
  localparam logic [4:0] OpAdd  = 5'b00100;
  localparam logic [4:0] OpAddi = 5'b00101;
  localparam logic [4:0] OpSub  = 5'b00110;
  localparam logic [4:0] OpSubi = 5'b00111;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StMemRd, StClr, StExec, StHalt
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;

  logic [4:0] op_d;
  logic       in_op_d;
  logic       is_mem_d, is_acc_d, is_neg_d;

  // Next-state logic. IR is captured on the DECODE exit edge only, so
  // DataAddr/ImmOut change only there.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      StIdle, StHalt: begin
        if (Start) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end
      StFetch:  state_d = StDecode;
      StDecode: begin
        ir_d = InstrIn;
        case (InstrIn[15:11])
          OpHlt:              state_d = StHalt;
          OpLd, OpAdd, OpSub: state_d = StMemRd;
          OpLdi:              state_d = StClr;
          default:            state_d = StExec;
        endcase
      end
      StMemRd:  state_d = (ir_q[15:11] == OpLd) ? StClr : StExec;
      StClr:    state_d = StExec;
      StExec: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = StFetch;
      end
      default:  state_d = StIdle;
    endcase
  end

  // Output decode is done on the next state so that the registered strobes
  // line up exactly with the state they belong to (Moore behaviour).
  always_comb begin
    op_d     = ir_d[15:11];
    in_op_d  = (state_d == StMemRd) || (state_d == StClr) || (state_d == StExec);
    is_mem_d = (op_d == OpLd) || (op_d == OpAdd) || (op_d == OpSub);
    is_neg_d = (op_d == OpSub) || (op_d == OpSubi);
    is_acc_d = is_mem_d || is_neg_d || (op_d == OpLdi) || (op_d == OpAddi);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      DataRd  <= 1'b0;
      DataWr  <= 1'b0;
      SelSrc  <= 1'b0;
      Negate  <= 1'b0;
      WrAcc   <= 1'b0;
      Clear   <= 1'b0;
      Busy    <= 1'b0;
      Halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      DataRd  <= (state_d == StMemRd);
      DataWr  <= (state_d == StExec) && (op_d == OpSto);
      SelSrc  <= in_op_d && is_mem_d;
      Negate  <= in_op_d && is_neg_d;
      WrAcc   <= (state_d == StExec) && is_acc_d;
      Clear   <= (state_d == StClr);
      Busy    <= (state_d != StIdle) && (state_d != StHalt);
      Halted  <= (state_d == StHalt);
    end
  end

  assign PcAddr   = pc_q;
  assign DataAddr = ir_q[10:0];
  assign ImmOut   = {{5{ir_q[10]}}, ir_q[10:0]};

endmodule

// File: tb/tb_bip_ctrl.sv
// Self-checking bench for bip_ctrl. Models the surrounding datapath (ROM,
// RAM, accumulator) and checks a per-cycle expected control trace that is
// built from the per-opcode cycle table when each program is loaded.
module tb_bip_ctrl;

  localparam logic [4:0] OpHlt  = 5'd0;
  localparam logic [4:0] OpSto  = 5'd1;
  localparam logic [4:0] OpLd   = 5'd2;
  localparam logic [4:0] OpLdi  = 5'd3;
  localparam logic [4:0] OpAdd  = 5'd4;
  localparam logic [4:0] OpAddi = 5'd5;
  localparam logic [4:0] OpSub  = 5'd6;
  localparam logic [4:0] OpSubi = 5'd7;

  // Control word bits: Busy Halted DataRd DataWr WrAcc Clear SelSrc Negate
  typedef struct {
    logic [7:0] ctl;
    logic [7:0] care;
    int         pc;
    int         addr;
    int         imm;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Reset, Start;
  logic [10:0] PcAddr, DataAddr;
  logic [15:0] InstrIn, ImmOut;
  logic        DataRd, DataWr, SelSrc, Negate, WrAcc, Clear, Busy, Halted;

  logic        reset2, start2;
  logic [1:0]  pc2;
  logic [10:0] daddr2;
  logic [15:0] instr2, imm2;
  logic        rd2, wr2, sel2, neg2, wracc2, clr2, busy2, halted2;

  bip_ctrl #(.PC_W(11)) dut (
    .clk(clk), .Reset(Reset), .Start(Start), .PcAddr(PcAddr), .InstrIn(InstrIn),
    .DataAddr(DataAddr), .DataRd(DataRd), .DataWr(DataWr), .SelSrc(SelSrc),
    .Negate(Negate), .ImmOut(ImmOut), .WrAcc(WrAcc), .Clear(Clear), .Busy(Busy),
    .Halted(Halted)
  );

  bip_ctrl #(.PC_W(2)) dut2 (
    .clk(clk), .Reset(reset2), .Start(start2), .PcAddr(pc2), .InstrIn(instr2),
    .DataAddr(daddr2), .DataRd(rd2), .DataWr(wr2), .SelSrc(sel2),
    .Negate(neg2), .ImmOut(imm2), .WrAcc(wracc2), .Clear(clr2), .Busy(busy2),
    .Halted(halted2)
  );

  // Datapath model
  logic [15:0] rom [0:2047];
  logic [15:0] ram [0:2047];
  logic [15:0] acc, rdata, opnd_sel, operand;
  assign opnd_sel = SelSrc ? rdata : ImmOut;
  assign operand  = Negate ? (~opnd_sel + 16'd1) : opnd_sel;

  always @(posedge clk) begin
    InstrIn <= rom[PcAddr];
    if (DataRd) rdata <= ram[DataAddr];
    if (DataWr) ram[DataAddr] <= acc;
    if (WrAcc) acc <= acc + operand;
    else if (Clear) acc <= '0;
  end

  exp_t        sb [$];
  int          sb_pc [$];
  logic [15:0] prog [$];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [10:0] v);
    return {op, v};
  endfunction

  function automatic exp_t mk(input logic [7:0] ctl, input logic [7:0] care,
                              input int pc, input int addr, input int imm);
    exp_t e;
    e.ctl = ctl; e.care = care; e.pc = pc; e.addr = addr; e.imm = imm;
    return e;
  endfunction

  task automatic push_fetch_decode(input int pc);
    sb.push_back(mk(8'h80, 8'hFC, pc, -1, -1));
    sb.push_back(mk(8'h80, 8'hFC, -1, -1, -1));
  endtask

  task automatic push_instr(input logic [15:0] w, input int pc);
    logic [4:0] op;
    int a, imm;
    op  = w[15:11];
    a   = int'(w[10:0]);
    imm = int'({{5{w[10]}}, w[10:0]});
    push_fetch_decode(pc);
    case (op)
      OpHlt:  sb.push_back(mk(8'h40, 8'hFF, -1, -1, -1));
      OpLd: begin
        sb.push_back(mk(8'hA2, 8'hFF, -1, a, -1));
        sb.push_back(mk(8'h86, 8'hFF, -1, -1, -1));
        sb.push_back(mk(8'h8A, 8'hFF, -1, -1, -1));
      end
      OpAdd: begin
        sb.push_back(mk(8'hA2, 8'hFF, -1, a, -1));
        sb.push_back(mk(8'h8A, 8'hFF, -1, -1, -1));
      end
      OpSub: begin
        sb.push_back(mk(8'hA3, 8'hFF, -1, a, -1));
        sb.push_back(mk(8'h8B, 8'hFF, -1, -1, -1));
      end
      OpLdi: begin
        sb.push_back(mk(8'h84, 8'hFF, -1, -1, -1));
        sb.push_back(mk(8'h88, 8'hFF, -1, -1, imm));
      end
      OpAddi: sb.push_back(mk(8'h88, 8'hFF, -1, -1, imm));
      OpSubi: sb.push_back(mk(8'h89, 8'hFF, -1, -1, imm));
      OpSto:  sb.push_back(mk(8'h90, 8'hFF, -1, a, -1));
      default: sb.push_back(mk(8'h80, 8'hFF, -1, -1, -1));
    endcase
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) begin
      rom[i] = prog[i];
      push_instr(prog[i], i);
    end
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  // Compare one expected entry per cycle; Start is raised at step glitch_at.
  task automatic drain(input int glitch_at);
    exp_t e;
    logic [7:0] obs;
    int step;
    step = 0;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = {Busy, Halted, DataRd, DataWr, WrAcc, Clear, SelSrc, Negate};
      vectors++;
      if ((obs & e.care) !== (e.ctl & e.care)) begin
        miscompares++;
        $display("FAIL ctl step %0d: got %b want %b (mask %b)", step, obs, e.ctl, e.care);
      end
      if (e.pc >= 0) begin
        vectors++;
        if (PcAddr !== 11'(e.pc)) begin
          miscompares++;
          $display("FAIL pc step %0d: got %0d want %0d", step, PcAddr, e.pc);
        end
      end
      if (e.addr >= 0) begin
        vectors++;
        if (DataAddr !== 11'(e.addr)) begin
          miscompares++;
          $display("FAIL daddr step %0d: got %0d want %0d", step, DataAddr, e.addr);
        end
      end
      if (e.imm >= 0) begin
        vectors++;
        if (ImmOut !== 16'(e.imm)) begin
          miscompares++;
          $display("FAIL imm step %0d: got %h want %h", step, ImmOut, 16'(e.imm));
        end
      end
      Start = (step == glitch_at);
      @(negedge clk);
      step++;
    end
    Start = 1'b0;
  endtask

  task automatic check_acc(input string name, input logic [15:0] want);
    vectors++;
    if (acc !== want) begin
      miscompares++;
      $display("FAIL %s: acc got %h want %h", name, acc, want);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [7:0] obs;
    obs = {Busy, Halted, DataRd, DataWr, WrAcc, Clear, SelSrc, Negate};
    vectors++;
    if (obs !== 8'h00 || PcAddr !== 11'd0 || DataAddr !== 11'd0 || ImmOut !== 16'd0) begin
      miscompares++;
      $display("FAIL %s: ctl %b pc %0d daddr %0d imm %h want all zero",
               name, obs, PcAddr, DataAddr, ImmOut);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; reset2 = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    Reset = 1'b0; reset2 = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_immediate();
    prog = {enc(OpLdi, 11'd5), enc(OpAddi, 11'd3), enc(OpSubi, 11'd1), enc(OpHlt, 11'd0)};
    load_prog();
    start_pulse();
    drain(-1);
    check_acc("imm_prog", 16'h0007);
  endtask

  task automatic test_memory();
    ram[4] = 16'h0010;
    prog = {enc(OpLd, 11'd4), enc(OpAdd, 11'd4), enc(OpSto, 11'd9), enc(OpHlt, 11'd0)};
    load_prog();
    start_pulse();
    drain(-1);
    check_acc("mem_prog", 16'h0020);
    vectors++;
    if (ram[9] !== 16'h0020) begin
      miscompares++;
      $display("FAIL sto_ram9: got %h want 0020", ram[9]);
    end
  endtask

  task automatic test_restart_from_halt();
    prog = {enc(OpAddi, 11'd1), enc(OpHlt, 11'd0)};
    load_prog();
    start_pulse();
    drain(-1);
    check_acc("restart_keeps_acc", 16'h0021);
  endtask

  task automatic test_sign_extend();
    prog = {enc(OpLdi, 11'h7FF), enc(OpSubi, 11'h400), enc(OpHlt, 11'd0)};
    load_prog();
    start_pulse();
    drain(-1);
    check_acc("sext_prog", 16'h03FF);
  endtask

  task automatic test_start_ignored();
    prog = {enc(OpAddi, 11'd2), enc(OpAddi, 11'd3), enc(OpHlt, 11'd0)};
    load_prog();
    start_pulse();
    drain(4);
    check_acc("start_ignored", 16'h0404);
  endtask

  task automatic test_reset_mid_instr();
    ram[4] = 16'h0010;
    prog = {enc(OpAdd, 11'd4), enc(OpHlt, 11'd0)};
    rom[0] = prog[0];
    rom[1] = prog[1];
    push_fetch_decode(0);
    start_pulse();
    drain(-1);
    vectors++;
    if (DataRd !== 1'b1) begin
      miscompares++;
      $display("FAIL memrd_before_reset: DataRd got %b want 1", DataRd);
    end
    Reset = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid");
    Reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_mid_reset");
    check_acc("acc_kept_over_reset", 16'h0404);
    load_prog();
    start_pulse();
    drain(-1);
    check_acc("after_mid_reset", 16'h0414);
  endtask

  task automatic test_nop_wrap();
    logic [3:0] strobes;
    int want;
    for (int i = 0; i < 5; i++) sb_pc.push_back(i % 4);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k < 15; k++) begin
      strobes = {rd2, wr2, wracc2, clr2};
      vectors++;
      if (strobes !== 4'b0000 || busy2 !== 1'b1) begin
        miscompares++;
        $display("FAIL nop_strobes cycle %0d: strobes %b busy %b want 0000/1",
                 k, strobes, busy2);
      end
      if (k % 3 == 0) begin
        want = sb_pc.pop_front();
        vectors++;
        if (pc2 !== 2'(want)) begin
          miscompares++;
          $display("FAIL nop_pc cycle %0d: got %0d want %0d", k, pc2, want);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; reset2 = 1'b1; start2 = 1'b0;
    instr2 = 16'hF800;
    for (int i = 0; i < 2048; i++) begin
      rom[i] = 16'hF800;
      ram[i] = 16'h0000;
    end
    @(negedge clk);
    test_reset();
    test_immediate();
    test_memory();
    test_restart_from_halt();
    test_sign_extend();
    test_start_ignored();
    test_reset_mid_instr();
    test_nop_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
